// File: rtl/exidle_rx.sv
// exidle_rx: strips exbus idle/FIFO-error words, recovers far-end aux/CTS/interrupt state and link health (EXIDLE_RX_ERRCOUNT_EN enables o_err_count)
module exidle_rx #(
  parameter int LGTIMEOUT  = 26,
  parameter int SYNC_IDLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [34:0] i_word,
  output logic        o_busy,
  output logic        o_stb,
  output logic [34:0] o_word,
  input  logic        i_busy,
  output logic [1:0]  o_aux,
  output logic        o_cts,
  output logic        o_int,
  output logic        o_fifo_err,
  output logic        o_linked,
  output logic        o_drop,
  output logic [7:0]  o_err_count
);
  typedef enum logic [1:0] {LOST, SYNCING, LINKED} state_t;
  state_t state;
  logic [3:0] idle_cnt;
  logic [3:0] cnt_inc;
  logic [LGTIMEOUT-1:0] wd;
  logic accept;
  logic special;
  logic idle;
  logic ferr;
  logic pass;
  logic expire;
  assign o_busy  = o_stb && i_busy;
  assign accept  = i_stb && !o_busy;
  assign special = i_word[34:33] == 2'b11;
  assign idle    = special && i_word[30];
  assign ferr    = special && i_word[30:28] == 3'b011;
  assign pass    = accept && !idle && !ferr;
  assign expire  = !accept && wd == {{(LGTIMEOUT-1){1'b1}}, 1'b0};
  assign cnt_inc = (state == LOST) ? 4'd1 : idle_cnt + 4'd1;
  // watchdog: cleared by any accepted word, saturates at all-ones
  always_ff @(posedge i_clk)
    if (i_reset || accept)
      wd <= '0;
    else if (!(&wd))
      wd <= wd + 1'b1;
  // link state machine; an accept in the expiry cycle keeps the link
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state    <= LOST;
      idle_cnt <= '0;
      o_linked <= 1'b0;
    end else if (expire) begin
      state    <= LOST;
      o_linked <= 1'b0;
    end else if (accept && idle && state != LINKED) begin
      idle_cnt <= cnt_inc;
      state    <= (cnt_inc == 4'(SYNC_IDLES)) ? LINKED : SYNCING;
      o_linked <= cnt_inc == 4'(SYNC_IDLES);
    end else if (pass && state == SYNCING)
      idle_cnt <= '0;
  // far-end status recovered from special words
  always_ff @(posedge i_clk)
    if (i_reset) begin
      o_aux      <= 2'b00;
      o_cts      <= 1'b0;
      o_int      <= 1'b0;
      o_fifo_err <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_int      <= accept && idle && i_word[28];
      o_fifo_err <= accept && ferr;
      o_drop     <= pass && state != LINKED;
      if (accept && special)
        o_aux <= i_word[32:31];
      if (expire)
        o_cts <= 1'b0;
      else if (accept && idle)
        o_cts <= i_word[29];
    end
  // forwarding register, held while downstream stalls
  always_ff @(posedge i_clk)
    if (i_reset) begin
      o_stb  <= 1'b0;
      o_word <= '0;
    end else if (pass && state == LINKED) begin
      o_stb  <= 1'b1;
      o_word <= i_word;
    end else if (!i_busy)
      o_stb <= 1'b0;
`ifdef EXIDLE_RX_ERRCOUNT_EN
  // saturating count of far-end FIFO-error reports
  always_ff @(posedge i_clk)
    if (i_reset)
      o_err_count <= 8'h00;
    else if (accept && ferr && !(&o_err_count))
      o_err_count <= o_err_count + 8'h01;
`else
  assign o_err_count = 8'h00;
`endif
endmodule

// File: tb/tb_exidle_rx.sv
// tb_exidle_rx: table-driven and scoreboard checks for exidle_rx
module tb_exidle_rx;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [34:0] i_word = '0;
  logic        i_busy = 1'b0;
  logic        o_busy, o_stb, o_cts, o_int, o_fifo_err, o_linked, o_drop;
  logic [34:0] o_word;
  logic [1:0]  o_aux;
  logic [7:0]  o_err_count;
  int n_chk = 0;
  int n_pass = 0;
  logic [34:0] sb[$];
`ifdef EXIDLE_RX_ERRCOUNT_EN
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif
  localparam logic [34:0] D1 = 35'h0_1234_5678;
  localparam logic [34:0] D2 = 35'h0_5555_AAAA;
  localparam logic [34:0] D3 = 35'h0_0BAD_F00D;

  exidle_rx #(.LGTIMEOUT(6), .SYNC_IDLES(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_word(i_word),
    .o_busy(o_busy), .o_stb(o_stb), .o_word(o_word), .i_busy(i_busy),
    .o_aux(o_aux), .o_cts(o_cts), .o_int(o_int), .o_fifo_err(o_fifo_err),
    .o_linked(o_linked), .o_drop(o_drop), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        stb;
    logic [34:0] w;
    logic        fwd, lnk;
    logic [1:0]  aux;
    logic        cts, intr, fe, drop;
    logic [7:0]  ec;
  } vec_t;
  vec_t tv[18];

  function automatic logic [34:0] fidle(input logic [1:0] aux, input logic cts, input logic intr);
    return {2'b11, aux, 1'b1, cts, intr, 28'h0};
  endfunction
  function automatic logic [34:0] fferr(input logic [1:0] aux);
    return {2'b11, aux, 3'b011, 28'h0};
  endfunction
  function automatic logic [34:0] fosp(input logic [1:0] aux);
    return {2'b11, aux, 3'b001, 28'h0ABCDEF};
  endfunction
  function automatic vec_t mk(input logic stb, input logic [34:0] w, input logic fwd, input logic lnk,
                              input logic [1:0] aux, input logic cts, input logic intr, input logic fe,
                              input logic drop, input logic [7:0] ec);
    vec_t v;
    v.stb = stb; v.w = w; v.fwd = fwd; v.lnk = lnk; v.aux = aux;
    v.cts = cts; v.intr = intr; v.fe = fe; v.drop = drop; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string n, input logic [34:0] a, input logic [34:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // scoreboard: pop on every downstream transfer
  always @(negedge i_clk)
    if (!i_reset && o_stb && !i_busy) begin
      if (sb.size() == 0)
        chk("unexpected_fwd", o_word, 35'h0);
      else
        chk("fwd_word", o_word, sb.pop_front());
    end

  initial begin
    tv[0]  = mk(1, D1,                   0, 0, 2'b00, 0, 0, 0, 1, 0);
    tv[1]  = mk(1, fidle(2'b10, 1, 0),   0, 0, 2'b10, 1, 0, 0, 0, 0);
    tv[2]  = mk(1, fidle(2'b10, 1, 0),   0, 0, 2'b10, 1, 0, 0, 0, 0);
    tv[3]  = mk(1, D1,                   0, 0, 2'b10, 1, 0, 0, 1, 0);
    tv[4]  = mk(1, fidle(2'b10, 1, 0),   0, 0, 2'b10, 1, 0, 0, 0, 0);
    tv[5]  = mk(1, fferr(2'b01),         0, 0, 2'b01, 1, 0, 1, 0, 1);
    tv[6]  = mk(1, fidle(2'b10, 1, 0),   0, 0, 2'b10, 1, 0, 0, 0, 1);
    tv[7]  = mk(1, fidle(2'b10, 1, 0),   0, 0, 2'b10, 1, 0, 0, 0, 1);
    tv[8]  = mk(1, fidle(2'b10, 1, 0),   0, 1, 2'b10, 1, 0, 0, 0, 1);
    tv[9]  = mk(0, 35'h0,                0, 1, 2'b10, 1, 0, 0, 0, 1);
    tv[10] = mk(1, D1,                   1, 1, 2'b10, 1, 0, 0, 0, 1);
    tv[11] = mk(1, fidle(2'b01, 1, 1),   0, 1, 2'b01, 1, 1, 0, 0, 1);
    tv[12] = mk(0, 35'h0,                0, 1, 2'b01, 1, 0, 0, 0, 1);
    tv[13] = mk(1, fferr(2'b11),         0, 1, 2'b11, 1, 0, 1, 0, 2);
    tv[14] = mk(1, fosp(2'b00),          1, 1, 2'b00, 1, 0, 0, 0, 2);
    tv[15] = mk(1, D3,                   1, 1, 2'b00, 1, 0, 0, 0, 2);
    tv[16] = mk(1, fidle(2'b10, 0, 0),   0, 1, 2'b10, 0, 0, 0, 0, 2);
    tv[17] = mk(1, fidle(2'b10, 1, 0),   0, 1, 2'b10, 1, 0, 0, 0, 2);
    repeat (2) tick();
    chk("rst_stb", 35'(o_stb), 35'h0);
    chk("rst_linked", 35'(o_linked), 35'h0);
    chk("rst_aux", 35'(o_aux), 35'h0);
    chk("rst_cts", 35'(o_cts), 35'h0);
    chk("rst_flags", 35'({o_int, o_fifo_err, o_drop, o_busy}), 35'h0);
    chk("rst_errcnt", 35'(o_err_count), 35'h0);
    i_reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      i_stb = tv[i].stb;
      i_word = tv[i].w;
      if (tv[i].stb && tv[i].fwd) sb.push_back(tv[i].w);
      tick();
      chk($sformatf("v%0d_linked", i), 35'(o_linked), 35'(tv[i].lnk));
      chk($sformatf("v%0d_aux", i), 35'(o_aux), 35'(tv[i].aux));
      chk($sformatf("v%0d_cts", i), 35'(o_cts), 35'(tv[i].cts));
      chk($sformatf("v%0d_int", i), 35'(o_int), 35'(tv[i].intr));
      chk($sformatf("v%0d_ferr", i), 35'(o_fifo_err), 35'(tv[i].fe));
      chk($sformatf("v%0d_drop", i), 35'(o_drop), 35'(tv[i].drop));
      chk($sformatf("v%0d_stb", i), 35'(o_stb), 35'(tv[i].fwd));
      chk($sformatf("v%0d_errcnt", i), 35'(o_err_count), ERRC ? 35'(tv[i].ec) : 35'h0);
    end
    // downstream stall holds the word; a word offered meanwhile waits
    i_busy = 1'b1;
    i_stb = 1'b1;
    i_word = D1;
    sb.push_back(D1);
    tick();
    i_word = D2;
    for (int k = 0; k < 3; k++) begin
      chk("busy_stb", 35'(o_stb), 35'h1);
      chk("busy_word", o_word, D1);
      chk("busy_obusy", 35'(o_busy), 35'h1);
      tick();
    end
    i_busy = 1'b0;
    sb.push_back(D2);
    tick();
    chk("b2b_word", o_word, D2);
    chk("b2b_stb", 35'(o_stb), 35'h1);
    i_stb = 1'b0;
    tick();
    chk("release_stb", 35'(o_stb), 35'h0);
    // watchdog boundary: accept on the expiry cycle keeps the link
    i_stb = 1'b1;
    i_word = fidle(2'b10, 1, 0);
    tick();
    i_stb = 1'b0;
    repeat (62) tick();
    chk("wd62_linked", 35'(o_linked), 35'h1);
    i_stb = 1'b1;
    i_word = fidle(2'b11, 1, 0);
    tick();
    chk("wd_race_linked", 35'(o_linked), 35'h1);
    chk("wd_race_aux", 35'(o_aux), 35'h3);
    i_stb = 1'b0;
    repeat (62) tick();
    chk("wd62b_linked", 35'(o_linked), 35'h1);
    chk("wd62b_cts", 35'(o_cts), 35'h1);
    tick();
    chk("wd_exp_linked", 35'(o_linked), 35'h0);
    chk("wd_exp_cts", 35'(o_cts), 35'h0);
    i_stb = 1'b1;
    i_word = D1;
    tick();
    chk("lost_drop", 35'(o_drop), 35'h1);
    chk("lost_stb", 35'(o_stb), 35'h0);
    // relink, then reset while a word is stalled
    i_word = fidle(2'b10, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("relink%0d", k), 35'(o_linked), (k == 3) ? 35'h1 : 35'h0);
    end
    i_busy = 1'b1;
    i_word = D3;
    tick();
    chk("pre_rst_stb", 35'(o_stb), 35'h1);
    i_stb = 1'b0;
    i_reset = 1'b1;
    tick();
    chk("midrst_stb", 35'(o_stb), 35'h0);
    chk("midrst_busy", 35'(o_busy), 35'h0);
    chk("midrst_word", o_word, 35'h0);
    chk("midrst_linked", 35'(o_linked), 35'h0);
    chk("midrst_cts_aux", 35'({o_cts, o_aux}), 35'h0);
    chk("midrst_flags", 35'({o_int, o_fifo_err, o_drop}), 35'h0);
    chk("midrst_errcnt", 35'(o_err_count), 35'h0);
    i_reset = 1'b0;
    i_busy = 1'b0;
    repeat (3) tick();
    chk("sb_empty", 35'(sb.size()), 35'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
